// File: rtl/sram_fifo_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_arbiter_pkg
// Shared definitions for the SRAM FIFO write arbiter:
//   - arb_state_t     : control FSM states (IDLE, RUN, FLUSH)
//   - FIFO_CAPACITY   : usable words for the default depth
//   - fifo_capacity() : usable words for any depth (one slot is always kept
//                       empty so that full and empty stay distinguishable)
// -----------------------------------------------------------------------------
package sram_fifo_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    localparam int unsigned DEFAULT_WORD_DEPTH = 32'd8;
    localparam int unsigned FIFO_CAPACITY      = DEFAULT_WORD_DEPTH - 32'd1;

    // Usable occupancy of a FIFO that keeps one slot empty.
    function automatic int unsigned fifo_capacity(input int unsigned depth);
        return depth - 32'd1;
    endfunction

endpackage : sram_fifo_arbiter_pkg

// File: rtl/sram_fifo_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. The search starts at last_grant+1 and
// wraps modulo N; the first requesting index found wins.
// Ports:
//   req_vec      in  N     request vector
//   last_grant   in  ID_W  index granted most recently
//   grant_onehot out N     one-hot winner (all zero when nothing requests)
//   grant_idx    out ID_W  winner index (zero when nothing requests)
//   grant_any    out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_vec,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant_onehot,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    logic [N-1:0]    onehot_s;
    logic [ID_W-1:0] idx_s;
    logic            any_s;
    logic [ID_W-1:0] cand_s;

    // Rotating priority search: offsets 1..N from the last grant.
    always_comb begin
        onehot_s = '0;
        idx_s    = '0;
        any_s    = 1'b0;
        cand_s   = '0;
        for (int off = 1; off <= N; off++) begin
            cand_s = ID_W'((int'(last_grant) + off) % N);
            if (!any_s && req_vec[cand_s]) begin
                any_s            = 1'b1;
                idx_s            = cand_s;
                onehot_s[cand_s] = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

    assign grant_onehot = onehot_s;
    assign grant_idx    = idx_s;
    assign grant_any    = any_s;

endmodule : rr_picker

// File: rtl/sram_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// sram_fifo_arbiter
// Arbitrates NUM_REQ write requesters into one external SRAM FIFO and passes
// consumer pops through to it. Tracks committed occupancy so no more than
// WORD_DEPTH-1 words are ever in flight or stored, and supports a flush that
// drains the FIFO with all new traffic blocked.
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   req_valid      per-requester word available
//   req_data       requester i word at [i*BITS +: BITS]
//   req_ready      one-hot accept strobe (combinational)
//   pop / pop_ack  consumer read request / accepted this cycle (combinational)
//   flush          single-cycle drain request
//   flush_done     single-cycle pulse when the drain has finished
//   fifo_write     FIFO write strobe (registered, one cycle after accept)
//   fifo_data_in   FIFO write data (registered)
//   fifo_read      FIFO read strobe (combinational)
//   fifo_ready     FIFO non-empty
//   fifo_overflow  FIFO overflow flag
//   level          committed occupancy (registered)
//   grant_id       last accepted requester (registered)
//   err_overflow   sticky overflow error
// -----------------------------------------------------------------------------
module sram_fifo_arbiter
    import sram_fifo_arbiter_pkg::*;
#(
    parameter  int BITS       = 12,
    parameter  int NUM_REQ    = 4,
    parameter  int WORD_DEPTH = 8,
    parameter  int ADDR_WIDTH = 3,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    pop,
    output logic                    pop_ack,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    fifo_write,
    output logic [BITS-1:0]         fifo_data_in,
    output logic                    fifo_read,
    input  logic                    fifo_ready,
    input  logic                    fifo_overflow,
    output logic [ADDR_WIDTH-1:0]   level,
    output logic [ID_W-1:0]         grant_id,
    output logic                    err_overflow
);

    localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(fifo_capacity(WORD_DEPTH));

    arb_state_t              state_r;
    arb_state_t              state_s;
    logic [ADDR_WIDTH-1:0]   level_r;
    logic [ADDR_WIDTH-1:0]   level_s;
    logic [ID_W-1:0]         grant_r;
    logic                    fifo_write_r;
    logic [BITS-1:0]         fifo_data_r;
    logic                    err_r;
    logic                    flush_done_r;

    logic [NUM_REQ-1:0]      win_onehot_s;
    logic [ID_W-1:0]         win_idx_s;
    logic                    win_any_s;
    logic [BITS-1:0]         win_data_s;
    logic                    active_s;
    logic                    accept_s;
    logic                    read_s;
    logic                    rd_dec_s;
    logic                    drain_done_s;

    rr_picker #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_picker (
        .req_vec      (req_valid),
        .last_grant   (grant_r),
        .grant_onehot (win_onehot_s),
        .grant_idx    (win_idx_s),
        .grant_any    (win_any_s)
    );

    // Select the winning requester's word with constant slices.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == ID_W'(i)) begin
                win_data_s = req_data[i*BITS +: BITS];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Accept/read decisions; acceptance uses the registered level only, so a
    // pop at full frees the slot for the following cycle, never this one.
    always_comb begin
        active_s     = (state_r != ST_FLUSH);
        accept_s     = active_s && win_any_s && (level_r < CAP);
        read_s       = active_s ? (pop && fifo_ready) : fifo_ready;
        rd_dec_s     = read_s && (level_r != '0);
        drain_done_s = (state_r == ST_FLUSH) && (level_r == '0) && !fifo_write_r;
    end

    // Occupancy next value: +1 on accept, -1 on read, hold when both or neither.
    always_comb begin
        level_s = level_r;
        case ({accept_s, rd_dec_s})
            2'b10:   level_s = level_r + ADDR_WIDTH'(1);
            2'b01:   level_s = level_r - ADDR_WIDTH'(1);
            default: level_s = level_r;
        endcase
    end

    // Control FSM next state; a flush seen while already flushing is ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_s = ST_FLUSH;
                end else if ((|req_valid) || pop) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_s = ST_FLUSH;
                end else if (!(|req_valid) && !pop && !fifo_write_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (drain_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, occupancy, write pipeline stage, grant history and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            level_r      <= '0;
            grant_r      <= ID_W'(NUM_REQ - 1);
            fifo_write_r <= 1'b0;
            fifo_data_r  <= '0;
            err_r        <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            level_r      <= level_s;
            fifo_write_r <= accept_s;
            flush_done_r <= drain_done_s;
            err_r        <= err_r | fifo_overflow;
            if (accept_s) begin
                grant_r     <= win_idx_s;
                fifo_data_r <= win_data_s;
            end else begin
                grant_r     <= grant_r;
                fifo_data_r <= fifo_data_r;
            end
        end
    end

    assign req_ready    = accept_s ? win_onehot_s : '0;
    assign pop_ack      = active_s && pop && fifo_ready;
    assign fifo_read    = read_s;
    assign fifo_write   = fifo_write_r;
    assign fifo_data_in = fifo_data_r;
    assign level        = level_r;
    assign grant_id     = grant_r;
    assign err_overflow = err_r;
    assign flush_done   = flush_done_r;

endmodule : sram_fifo_arbiter

// File: tb/tb_sram_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_arbiter
// Drives directed scenarios and randomized traffic into sram_fifo_arbiter, with
// the external FIFO and the expected arbiter behaviour modelled by queues and
// counters inside the bench.
// -----------------------------------------------------------------------------
module tb_sram_fifo_arbiter;

    localparam int BITS       = 12;
    localparam int NUM_REQ    = 4;
    localparam int WORD_DEPTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int ID_W       = 2;
    localparam int CAP        = WORD_DEPTH - 1;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*BITS-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    pop;
    logic                    pop_ack;
    logic                    flush;
    logic                    flush_done;
    logic                    fifo_write;
    logic [BITS-1:0]         fifo_data_in;
    logic                    fifo_read;
    logic                    fifo_ready;
    logic                    fifo_overflow;
    logic [ADDR_WIDTH-1:0]   level;
    logic [ID_W-1:0]         grant_id;
    logic                    err_overflow;

    sram_fifo_arbiter #(
        .BITS       (BITS),
        .NUM_REQ    (NUM_REQ),
        .WORD_DEPTH (WORD_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .pop           (pop),
        .pop_ack       (pop_ack),
        .flush         (flush),
        .flush_done    (flush_done),
        .fifo_write    (fifo_write),
        .fifo_data_in  (fifo_data_in),
        .fifo_read     (fifo_read),
        .fifo_ready    (fifo_ready),
        .fifo_overflow (fifo_overflow),
        .level         (level),
        .grant_id      (grant_id),
        .err_overflow  (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requesters and external FIFO contents
    bit              rq_valid [NUM_REQ];
    logic [BITS-1:0] rq_data  [NUM_REQ];
    logic [BITS-1:0] fq[$];

    // Reference model of the arbiter's visible state
    int              m_level;
    int              m_last;
    bit              m_flush;
    bit              m_wr;
    logic [BITS-1:0] m_data;
    bit              m_done;
    bit              m_err;
    int              last_acc;

    // Last observed DUT outputs of the current cycle
    logic [NUM_REQ-1:0] obs_ready;
    logic               obs_read;
    logic               obs_ack;
    logic               obs_done;
    int                 obs_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]                 = rq_valid[i];
            req_data[i*BITS +: BITS]     = rq_data[i];
        end
    endtask

    // One clock cycle: inputs are already set (we sit just after a falling edge).
    task automatic run_cycle();
        int                 w;
        bit                 any;
        bit                 acc;
        bit                 fr;
        bit                 rd;
        bit                 ack;
        bit                 drain;
        bit                 wr_old;
        logic [BITS-1:0]    data_old;
        logic [NUM_REQ-1:0] exp_ready;
        drive_reqs();
        fifo_ready = (fq.size() != 0);
        #1;
        any = 1'b0;
        w   = 0;
        if (!m_flush) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                int c;
                c = (m_last + off) % NUM_REQ;
                if (!any && rq_valid[c]) begin
                    any = 1'b1;
                    w   = c;
                end
            end
        end
        acc       = !m_flush && any && (m_level < CAP);
        exp_ready = '0;
        if (acc) exp_ready[w] = 1'b1;
        fr  = (fq.size() != 0);
        rd  = m_flush ? fr : (pop && fr);
        ack = !m_flush && pop && fr;

        obs_ready = req_ready;
        obs_read  = fifo_read;
        obs_ack   = pop_ack;
        obs_done  = flush_done;
        obs_idx   = -1;
        for (int i = 0; i < NUM_REQ; i++) if (obs_ready[i]) obs_idx = i;

        check_eq("req_ready",    req_ready,    exp_ready);
        check_eq("pop_ack",      pop_ack,      ack);
        check_eq("fifo_read",    fifo_read,    rd);
        check_eq("level",        level,        m_level);
        check_eq("grant_id",     grant_id,     m_last);
        check_eq("fifo_write",   fifo_write,   m_wr);
        check_eq("fifo_data_in", fifo_data_in, m_data);
        check_eq("flush_done",   flush_done,   m_done);
        check_eq("err_overflow", err_overflow, m_err);

        // Advance the model to the values expected after the rising edge
        drain    = m_flush && (m_level == 0) && !m_wr;
        wr_old   = m_wr;
        data_old = m_data;
        m_wr     = acc;
        if (acc) begin
            m_data = rq_data[w];
            m_last = w;
        end
        if (acc && !rd)                     m_level++;
        else if (!acc && rd && m_level > 0) m_level--;
        if (!m_flush && flush) m_flush = 1'b1;
        else if (drain)        m_flush = 1'b0;
        m_done = drain;
        m_err  = m_err | fifo_overflow;
        if (rd)     void'(fq.pop_front());
        if (wr_old) fq.push_back(data_old);
        last_acc = acc ? w : -1;
        if (acc) rq_valid[w] = 1'b0;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_valid[i] = 1'b0;
            rq_data[i]  = '0;
        end
        pop           = 1'b0;
        flush         = 1'b0;
        fifo_overflow = 1'b0;
        drive_reqs();
    endtask

    // Asynchronous reset asserted away from the clock edge; registered outputs checked at once.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_level"},      level,        0);
        check_eq({tag, "_grant_id"},   grant_id,     NUM_REQ - 1);
        check_eq({tag, "_fifo_write"}, fifo_write,   0);
        check_eq({tag, "_fifo_data"},  fifo_data_in, 0);
        check_eq({tag, "_err"},        err_overflow, 0);
        check_eq({tag, "_flush_done"}, flush_done,   0);
        clear_inputs();
        fq.delete();
        fifo_ready = 1'b0;
        m_level = 0; m_last = NUM_REQ - 1; m_flush = 1'b0; m_wr = 1'b0;
        m_data = '0; m_done = 1'b0; m_err = 1'b0; last_acc = -1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < NUM_REQ; i++) rq_valid[i] = 1'b0;
        pop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (m_level == 0 && fq.size() == 0 && !m_wr) break;
            run_cycle();
        end
        pop = 1'b0;
        run_cycle();
        check_eq("drain_level", level, 0);
    endtask

    // Write n words from requester r, reloading it after each acceptance.
    task automatic fill(input int r, input int n);
        int got;
        got = 0;
        for (int k = 0; k < 3 * n && got < n; k++) begin
            if (!rq_valid[r]) begin
                rq_valid[r] = 1'b1;
                rq_data[r]  = BITS'($urandom);
            end
            run_cycle();
            if (last_acc == r) got++;
        end
        rq_valid[r] = 1'b0;
    endtask

    task automatic random_phase(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rq_valid[i] && $urandom_range(0, 2) == 0) begin
                    rq_valid[i] = 1'b1;
                    rq_data[i]  = BITS'($urandom);
                end
            end
            pop   = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 39) == 0);
            run_cycle();
        end
        flush = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int exp_order [5];
        int rd_count;
        bit done_seen;
        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        clear_inputs();
        fifo_ready = 1'b0;
        @(negedge clk);
        apply_reset("reset");

        // Round-robin order with all four requesters valid
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_valid[i] = 1'b1;
            rq_data[i]  = BITS'(32'h100 + i);
        end
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            check_eq($sformatf("rr_order%0d", k), obs_idx, exp_order[k]);
            if (last_acc >= 0) begin
                rq_valid[last_acc] = 1'b1;
                rq_data[last_acc]  = rq_data[last_acc] + BITS'(4);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) rq_valid[i] = 1'b0;
        check_eq("rr_level", level, 5);
        drain();

        // Fill to capacity, blocked at full, pop frees a slot next cycle
        fill(1, 7);
        check_eq("full_level", level, CAP);
        rq_valid[1] = 1'b1;
        rq_data[1]  = 12'h5a5;
        run_cycle();
        check_eq("full_block", obs_ready, 0);
        pop = 1'b1;
        run_cycle();
        check_eq("full_pop_block", obs_ready, 0);
        pop = 1'b0;
        check_eq("full_pop_level", level, CAP - 1);
        run_cycle();
        check_eq("full_reuse", obs_ready, 4'b0010);
        check_eq("full_relevel", level, CAP);
        drain();

        // Accept and pop together at level 3
        fill(2, 3);
        check_eq("both_pre", level, 3);
        rq_valid[2] = 1'b1;
        rq_data[2]  = 12'h333;
        pop = 1'b1;
        run_cycle();
        check_eq("both_acc", obs_ready, 4'b0100);
        check_eq("both_read", obs_read, 1);
        pop = 1'b0;
        check_eq("both_level", level, 3);
        drain();

        // Pop against an empty FIFO
        pop = 1'b1;
        run_cycle();
        check_eq("empty_ack", obs_ack, 0);
        check_eq("empty_read", obs_read, 0);
        check_eq("empty_level", level, 0);
        pop = 1'b0;

        // Flush of five stored words with requesters pushing throughout
        fill(3, 5);
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_valid[i] = 1'b1;
            rq_data[i]  = BITS'($urandom);
        end
        rd_count  = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 20 && !done_seen; k++) begin
            flush = (k == 2);
            run_cycle();
            rd_count += int'(obs_read);
            if (obs_done) done_seen = 1'b1;
        end
        flush = 1'b0;
        check_eq("flush_done_seen", done_seen, 1);
        check_eq("flush_reads", rd_count, 5);
        drain();

        // Sticky overflow, then random traffic, then reset mid-stream
        fifo_overflow = 1'b1;
        run_cycle();
        fifo_overflow = 1'b0;
        run_cycle();
        check_eq("ovf_sticky", err_overflow, 1);
        random_phase(300);
        check_eq("ovf_hold", err_overflow, 1);
        apply_reset("midreset");
        random_phase(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_fifo_arbiter
